load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Data-memory stage downstream of the ALU: consumes the ALU Result as effective address, issues
//   one byte/half/word load or store to data memory over a req/ready handshake, and returns the
//   sign/zero-extended load value to writeback. Asserts busy so the core stalls PC/regfile writes
//   until done. Detects misalignment and memory timeout.
// PARAMETERS
//   TIMEOUT  255  REQ cycles without mem_ready before err; 0 = no timeout (wait forever)
//   CNT_W    8    timeout counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//   clk         in   1   core clock, rising edge
//   rst         in   1   asynchronous, active-low reset
//   start       in   1   request pulse from control; sampled only in IDLE
//   we          in   1   1 = store, 0 = load
//   funct3      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only)
//   addr        in   32  effective address (ALU Result)
//   wdata       in   32  store data (rs2), right-aligned
//   busy        out  1   state != IDLE
//   done        out  1   one-cycle completion pulse
//   err         out  1   valid with done: misaligned, illegal funct3 or timeout
//   rdata       out  32  extended load data, valid with done, held until next completion
//   mem_req     out  1   memory request, held high until mem_ready
//   mem_we      out  1   write enable, stable while mem_req
//   mem_addr    out  32  word address: {addr[31:2],2'b00}
//   mem_wstrb   out  4   byte strobes (0000 for loads)
//   mem_wdata   out  32  store data shifted to byte lane
//   mem_ready   in   1   memory accepts/completes request this cycle
//   mem_rdata   in   32  read word, valid when mem_ready && !mem_we
// BEHAVIOUR
//   Reset (async, rst=0): state IDLE; busy, done, err, mem_req, mem_we = 0; rdata, mem_addr,
//     mem_wstrb, mem_wdata, timeout counter = 0. Reset mid-transaction aborts it; mem_req falls
//     asynchronously, and no done is produced.
//   FSM (registered outputs), states IDLE, REQ, RESP:
//     IDLE: start && legal && aligned -> latch we/funct3/addr[1:0], drive mem_* -> REQ.
//           start && (misaligned || illegal funct3) -> RESP with err=1; no mem_req ever raised.
//           start=0 -> stay.
//     REQ:  mem_req=1. mem_ready=1 -> capture formatted load data (loads) -> RESP, err=0.
//           else counter++; counter==TIMEOUT-1 (TIMEOUT!=0) -> RESP, err=1, mem_req drops.
//     RESP: done=1 for exactly one cycle -> IDLE; counter cleared.
//   start outside IDLE is ignored. Not queued.
//   Latency: start at edge N -> mem_req high after N; mem_ready at N+k -> done high after N+k.
//     Zero-wait memory: done 2 cycles after start. Error path: done 1 cycle after start.
//   Alignment: H/HU needs addr[0]=0; W needs addr[1:0]=00; B/BU any. Illegal: 011, 110, 111;
//     store funct3 1xx.
//   Strobes: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111; mem_wdata=wdata<<(8*addr[1:0]).
//   Load: byte/half selected by latched addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend.
//   rdata on store or err completion: unchanged (not cleared).
//   Simultaneous mem_ready and timeout in the same cycle: mem_ready wins (no err).
//   mem_ready in IDLE/RESP is ignored. Address wrap is not checked; mem_addr just truncates 1:0.
// STRUCTURE
//   lsu_pkg: funct3 constants (F3_B..F3_HU), state enum {IDLE,REQ,RESP}, strobe constants.
//   Sub-module lsu_align (combinational): funct3+addr[1:0]+wdata -> wstrb/wdata lane shift;
//     funct3+addr[1:0]+mem_rdata -> extended rdata; misaligned/illegal flags.
//   Top: FSM, timeout counter, output registers.
// TESTING
//   LW addr=0x100, mem_ready 1 cycle after req, rdata=0xDEADBEEF -> mem_addr=0x100, wstrb=0000,
//     done 2 cycles after start, rdata=0xDEADBEEF, err=0.
//   LB addr=0x103, mem_rdata=0x80FF_FF_FF -> rdata=0xFFFFFF80; same with LBU -> 0x00000080.
//   SH addr=0x202, wdata=0x1234ABCD, mem_ready after 3 waits -> wstrb=1100, wdata=0xABCD0000,
//     mem_req held 4 cycles with stable addr/data, busy until done.
//   LW addr=0x101 -> no mem_req, done+err next cycle, rdata unchanged; funct3=011 same response.
//   TIMEOUT=4, mem_ready never -> mem_req 4 cycles, then done+err=1, back to IDLE;
//     second start during REQ ignored.
//   rst low mid-REQ -> mem_req, busy 0 immediately; no done; next LW after release completes.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: access-size encodings,
// FSM state encoding and byte-strobe patterns.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: moves store data onto its byte lanes, builds the
// byte strobes, extracts and extends load data, and flags illegal encodings
// and misaligned addresses.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        illegal,
  output logic        misaligned
);

  logic [31:0] shifted;

  assign wdata_lane = wdata << {lo, 3'b000};
  assign shifted    = mem_rdata >> {lo, 3'b000};

  // Legality and alignment; unsigned variants only exist for loads.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_B:  misaligned = 1'b0;
      F3_BU: illegal    = we;
      F3_H:  misaligned = lo[0];
      F3_HU: begin
        illegal    = we;
        misaligned = lo[0];
      end
      F3_W:  misaligned = (lo != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  // Byte strobes for stores; loads never strobe.
  always_comb begin
    wstrb = 4'b0000;
    if (we) begin
      case (funct3)
        F3_B:    wstrb = STRB_B << lo;
        F3_H:    wstrb = STRB_H << lo;
        F3_W:    wstrb = STRB_W;
        default: wstrb = 4'b0000;
      endcase
    end
  end

  // Load extraction: lane already shifted down, then sign/zero extend.
  always_comb begin
    rdata_ext = mem_rdata;
    case (funct3)
      F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
      F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
      default: rdata_ext = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: takes the ALU result as effective address, performs one
// byte/half/word access over a req/ready handshake and returns extended load
// data with a one-cycle done pulse.
//
// Handshake: mem_req rises with mem_we/mem_addr/mem_wstrb/mem_wdata valid and
// they all stay stable until a cycle in which mem_ready is sampled high; that
// cycle completes the access (mem_rdata is sampled then for loads) and mem_req
// drops on the following edge. mem_ready outside an active request is ignored.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  state_dbg
);

  // Last counter value before giving up; unused when TIMEOUT is 0.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  state_t state, state_n;

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]  f3_q, f3_n;
  logic [1:0]  lo_q, lo_n;
  logic        done_n, err_n, mem_req_n, mem_we_n;
  logic [31:0] rdata_n, mem_addr_n, mem_wdata_n;
  logic [3:0]  mem_wstrb_n;

  // Alignment block sees the live request in IDLE and the latched one after.
  logic [2:0]  al_f3;
  logic [1:0]  al_lo;
  logic        al_we;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_rdata;
  logic        al_illegal, al_misaligned;

  assign al_f3 = (state == IDLE) ? funct3    : f3_q;
  assign al_lo = (state == IDLE) ? addr[1:0] : lo_q;
  assign al_we = (state == IDLE) ? we        : mem_we;

  lsu_align u_align (
    .we         (al_we),
    .funct3     (al_f3),
    .lo         (al_lo),
    .wdata      (wdata),
    .mem_rdata  (mem_rdata),
    .wstrb      (al_wstrb),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata),
    .illegal    (al_illegal),
    .misaligned (al_misaligned)
  );

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Next-state and next-output logic for all registered outputs.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    f3_n        = f3_q;
    lo_n        = lo_q;
    done_n      = 1'b0;
    err_n       = 1'b0;
    rdata_n     = rdata;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wstrb_n = mem_wstrb;
    mem_wdata_n = mem_wdata;
    case (state)
      IDLE: begin
        if (start) begin
          if (al_illegal || al_misaligned) begin
            state_n = RESP;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else begin
            state_n     = REQ;
            cnt_n       = '0;
            f3_n        = funct3;
            lo_n        = addr[1:0];
            mem_req_n   = 1'b1;
            mem_we_n    = we;
            mem_addr_n  = {addr[31:2], 2'b00};
            mem_wstrb_n = al_wstrb;
            mem_wdata_n = al_wdata;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_n   = RESP;
          done_n    = 1'b1;
          mem_req_n = 1'b0;
          if (!mem_we) rdata_n = al_rdata;
        end else if (TO_EN && (cnt == CNT_LAST)) begin
          state_n   = RESP;
          done_n    = 1'b1;
          err_n     = 1'b1;
          mem_req_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n   = IDLE;
        mem_req_n = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      f3_q      <= 3'b000;
      lo_q      <= 2'b00;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'h0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      f3_q      <= f3_n;
      lo_q      <= lo_n;
      done      <= done_n;
      err       <= err_n;
      rdata     <= rdata_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wstrb <= mem_wstrb_n;
      mem_wdata <= mem_wdata_n;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized accesses checked
// against a byte-level model of the access rules.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata = 32'h0;

  load_store_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .we        (we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---- reference model (byte-level view of the access rules) ----
  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic model_bad(input logic w, input logic [2:0] f3, input logic [31:0] a);
    int sz = acc_size(f3);
    if (sz == 0) return 1'b1;
    if (w && f3[2]) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [3:0] model_strb(input logic w, input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m = 4'b0000;
    int off = int'(a % 4);
    if (!w) return 4'b0000;
    for (int b = 0; b < acc_size(f3); b++) m[off + b] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    logic [7:0]  bytes[4];
    logic [31:0] v = 32'h0;
    int off = int'(a % 4);
    int sz  = acc_size(f3);
    for (int b = 0; b < 4; b++) bytes[b] = word[8*b +: 8];
    for (int b = 0; b < sz; b++) v = v + (32'(bytes[off + b]) << (8 * b));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v + (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  // ---- driver: one access, acting as memory, with checks along the way ----
  task automatic run_txn(input logic t_we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] word, input int waits,
                         input bit poke_start);
    logic        exp_err;
    logic [31:0] held_addr;
    int          ncyc;
    @(negedge clk);
    start = 1'b1; we = t_we; funct3 = f3; addr = a; wdata = wd; mem_rdata = word;
    @(negedge clk);
    start = 1'b0;
    if (model_bad(t_we, f3, a)) begin
      exp_q.push_back(model_rdata);
      check("err_path_done", {31'h0, done}, 32'h1);
      check("err_path_err",  {31'h0, err}, 32'h1);
      check("err_path_noreq", {31'h0, mem_req}, 32'h0);
      check("err_path_rdata", rdata, exp_q.pop_front());
    end else begin
      held_addr = {a[31:2], 2'b00};
      check("req_addr",  mem_addr, held_addr);
      check("req_we",    {31'h0, mem_we}, {31'h0, t_we});
      check("req_strb",  {28'h0, mem_wstrb}, {28'h0, model_strb(t_we, f3, a)});
      if (t_we) check("req_wdata", mem_wdata, wd << (8 * (a % 4)));
      exp_err = (waits >= TO);
      ncyc    = exp_err ? TO : waits + 1;
      for (int k = 0; k < ncyc; k++) begin
        check("req_held", {31'h0, mem_req}, 32'h1);
        check("req_addr_stable", mem_addr, held_addr);
        check("req_busy", {31'h0, busy}, 32'h1);
        check("req_no_done", {31'h0, done}, 32'h0);
        mem_ready = (k == waits);
        if (poke_start && k == 1) begin
          start = 1'b1; we = ~t_we;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        start = 1'b0;
      end
      if (!exp_err && !t_we) model_rdata = model_load(f3, a, word);
      exp_q.push_back(model_rdata);
      check("resp_done", {31'h0, done}, 32'h1);
      check("resp_err",  {31'h0, err}, {31'h0, exp_err});
      check("resp_req_low", {31'h0, mem_req}, 32'h0);
      check("resp_rdata", rdata, exp_q.pop_front());
    end
    @(negedge clk);
    check("after_done_low", {31'h0, done}, 32'h0);
    check("after_idle", {31'h0, busy}, 32'h0);
    mem_rdata = 32'h0;
  endtask

  initial begin
    // reset state
    #12;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err",  {31'h0, err}, 32'h0);
    check("rst_req",  {31'h0, mem_req}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_strb", {28'h0, mem_wstrb}, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // directed cases
    run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    check("lw_value", rdata, 32'hDEAD_BEEF);
    run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 0, 1'b0);
    check("lb_value", rdata, 32'hFFFF_FF80);
    run_txn(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 1, 1'b0);
    check("lbu_value", rdata, 32'h0000_0080);
    run_txn(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 3, 1'b0);
    check("sh_keeps_rdata", rdata, 32'h0000_0080);
    run_txn(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h1111_1111, 0, 1'b0);
    run_txn(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h2222_2222, 0, 1'b0);
    run_txn(1'b1, 3'b100, 32'h0000_0100, 32'h5, 32'h0, 0, 1'b0);
    run_txn(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h3333_3333, 20, 1'b1);
    @(negedge clk);
    check("no_queued_start", {31'h0, busy}, 32'h0);

    // reset in the middle of a request
    @(negedge clk);
    start = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0400;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_req", {31'h0, mem_req}, 32'h1);
    rst = 1'b0;
    #1;
    check("async_rst_req", {31'h0, mem_req}, 32'h0);
    check("async_rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    check("rst_no_done", {31'h0, done}, 32'h0);
    check("rst_clr_rdata", rdata, 32'h0);
    model_rdata = 32'h0;
    rst = 1'b1;
    run_txn(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'hCAFE_F00D, 0, 1'b0);

    // randomized accesses
    for (int n = 0; n < 60; n++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_a;
      r_we = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 2))
          0: r_f3 = 3'b010;
          1: r_f3 = r_we ? 3'b001 : 3'b101;
          default: r_f3 = r_we ? 3'b000 : 3'b100;
        endcase
      end
      r_a = $urandom;
      if ($urandom_range(0, 2) != 0) r_a[1:0] = (acc_size(r_f3) == 4) ? 2'b00 :
                                                (acc_size(r_f3) == 2) ? {1'($urandom_range(0, 1)), 1'b0} :
                                                r_a[1:0];
      run_txn(r_we, r_f3, r_a, $urandom, $urandom, $urandom_range(0, 5), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
